control_fsm: RTL and testbench
==============================

Name: control_fsm

Overview:
- Parametrised multi-cycle successor to the processor's single-cycle control unit.
- Accepts one instruction at a time over a valid/ready handshake and sequences it through DECODE, EXEC and WB states.
- Drives register-file port addresses, datapath mux selects, ALU op, write enable and PC control.
- Adds branch-on-zero sampling, HALT, illegal-opcode detection and an optional write-protect on register 0.

Parameters:
INSTR_W, 36, instruction width in bits
OP_W, 4, opcode field width; the opcode occupies ir[OP_W-1:0]
REG_AW, 5, register address width
R0_PROTECT, 1, when 1 any write to register 0 is suppressed
IMM_W, INSTR_W-OP_W-3*REG_AW (17 at defaults), immediate width; derived, not to be overridden

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
instruction  in  INSTR_W  instruction word
instr_valid  in  1  instruction present
instr_ready  out  1  control can accept an instruction
z  in  1  ALU zero flag
alu_en  out  2  ALU op: 00 none, 01 ADD, 10 SUB, 11 AND
M1  out  2  ALU A source: 00 reg A, 01 PC, 10 zero
M2  out  1  ALU B source: 0 reg B, 1 immediate
M3  out  2  writeback source: 00 ALU, 01 immediate
M4  out  1  PC source: 0 PC+1, 1 branch target (immediate)
rpa  out  REG_AW  read port A address
rpb  out  REG_AW  read port B address
wpn  out  REG_AW  write port address
imm  out  IMM_W  immediate field
rst_en  out  1  datapath clear pulse
write_en  out  1  register-file write strobe
pc_load  out  1  PC update strobe
halted  out  1  HALT reached
illegal  out  1  one-cycle illegal-opcode pulse

Behaviour:
- Field layout of the instruction register ir, from LSB upward:
  - opcode = ir[OP_W-1:0]
  - rpa = next REG_AW bits
  - rpb = next REG_AW bits
  - wpn = next REG_AW bits
  - imm = remaining upper IMM_W bits
- Opcodes:
  - 0000 NOP
  - 0001 ADD
  - 0010 SUB
  - 0011 AND
  - 0100 LOADI
  - 0101 ADDI
  - 1000 JZ
  - 1001 JMP
  - 1111 HALT
  - all others illegal
- All outputs are registered (Moore on state and ir).
- Reset:
  - state=IDLE, ir=0, all outputs 0, except rst_en=1 while rst is high and for exactly one cycle after rst falls.
  - Reset mid-instruction aborts the instruction with no write_en and no pc_load.
- IDLE:
  - instr_ready=1.
  - On instr_valid & instr_ready at an edge, ir<=instruction and state goes to DECODE.
  - instruction is ignored when instr_ready=0.
- DECODE (1 cycle):
  - rpa/rpb/wpn/imm are driven from ir and held unchanged through WB.
  - Illegal opcode: illegal=1 for this cycle only, next state IDLE, no write_en, no pc_load.
  - HALT: next state HALT.
  - All other opcodes: next state EXEC.
- EXEC (1 cycle):
  - ADD/SUB/AND: alu_en=01/10/11, M1=00, M2=0.
  - ADDI: alu_en=01, M1=00, M2=1.
  - LOADI, NOP, JMP, JZ: alu_en=00.
  - JZ samples z at the end of EXEC into a taken flag.
  - alu_en is 00 in every other state.
- WB (1 cycle), then IDLE:
  - ADD/SUB/AND/ADDI: write_en=1, M3=00.
  - LOADI: write_en=1, M3=01.
  - If R0_PROTECT=1 and wpn=0, write_en stays 0.
  - pc_load=1 for every non-HALT legal instruction.
  - M4=1 for JMP, and for JZ only when taken; otherwise M4=0.
- Selects: M1/M2/M3/M4 hold their values from the state that set them until the next DECODE, then return to 0.
- Timing and latency:
  - Throughput is 4 cycles per instruction.
  - instr_ready is low from the acceptance edge until WB completes.
  - A back-to-back instruction is accepted on the first IDLE cycle after WB.
- HALT:
  - halted=1 and instr_ready=0, held until rst.
  - pc_load is never asserted for HALT.
- z changes outside EXEC have no effect.

Test Plan:
1. Reset for 3 cycles, then release.
   - rst_en=1 on those 3 cycles plus 1 more, then 0.
   - All other outputs 0; instr_ready=1 one cycle after release.
2. ADD with rpa=3, rpb=7, wpn=9.
   - DECODE: rpa=3, rpb=7, wpn=9.
   - EXEC: alu_en=01, M2=0.
   - WB: write_en=1, M3=00, pc_load=1, M4=0.
   - Next instruction accepted 4 cycles after the first.
3. LOADI with wpn=0 and imm=17'h1ABCD, R0_PROTECT=1.
   - WB: M3=01, imm=17'h1ABCD, write_en=0, pc_load=1.
   - Repeat with wpn=4: write_en=1.
4. JZ with z=1 in EXEC.
   - WB: M4=1, pc_load=1.
   - Repeat with z=0 in EXEC and z=1 in DECODE and WB: M4=0.
5. Opcode 0110.
   - illegal=1 for one cycle in DECODE, no write_en, no pc_load, back to IDLE.
   - Then HALT opcode: halted=1, instr_ready stays 0 while instr_valid toggles, until rst.
6. Assert rst during EXEC of ADD.
   - No write_en or pc_load at any point afterwards.
   - Outputs reset on the next edge, rst_en pulses as in scenario 1.

Source files
------------

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle instruction sequencer (IDLE -> DECODE -> EXEC -> WB).
// Every control output is a flop. Its next value is decoded from the next state
// and from the instruction register's next contents, so the outputs settle on
// the same edge that moves the state.
module control_fsm #(
    parameter int INSTR_W    = 36,
    parameter int OP_W       = 4,
    parameter int REG_AW     = 5,
    parameter int R0_PROTECT = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [INSTR_W-1:0]                 instruction,
    input  logic                               instr_valid,
    output logic                               instr_ready,
    input  logic                               z,
    output logic [1:0]                         alu_en,
    output logic [1:0]                         M1,
    output logic                               M2,
    output logic [1:0]                         M3,
    output logic                               M4,
    output logic [REG_AW-1:0]                  rpa,
    output logic [REG_AW-1:0]                  rpb,
    output logic [REG_AW-1:0]                  wpn,
    output logic [INSTR_W-OP_W-3*REG_AW-1:0]   imm,
    output logic                               rst_en,
    output logic                               write_en,
    output logic                               pc_load,
    output logic                               halted,
    output logic                               illegal
);

    localparam int IMM_W = INSTR_W - OP_W - 3*REG_AW;

    localparam logic [OP_W-1:0] OP_NOP   = OP_W'(4'h0);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(4'h1);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(4'h2);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(4'h3);
    localparam logic [OP_W-1:0] OP_LOADI = OP_W'(4'h4);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(4'h5);
    localparam logic [OP_W-1:0] OP_JZ    = OP_W'(4'h8);
    localparam logic [OP_W-1:0] OP_JMP   = OP_W'(4'h9);
    localparam logic [OP_W-1:0] OP_HALT  = OP_W'(4'hF);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t             state, next_state;
    logic [INSTR_W-1:0] ir, ir_d;
    logic               rst_q;
    logic               accept;

    logic [OP_W-1:0]    op_d;
    logic [REG_AW-1:0]  wpn_d;
    logic               legal_d;
    logic               writes_d;

    logic               instr_ready_d, halted_d, illegal_d;
    logic               write_en_d, pc_load_d;
    logic [1:0]         alu_en_d, m1_d, m3_d;
    logic               m2_d, m4_d;

    // Register-file addresses and immediate are plain field slices of ir,
    // so they stay fixed from DECODE until the next instruction is accepted.
    assign rpa = ir[OP_W +: REG_AW];
    assign rpb = ir[OP_W + REG_AW +: REG_AW];
    assign wpn = ir[OP_W + 2*REG_AW +: REG_AW];
    assign imm = ir[INSTR_W-1 -: IMM_W];

    assign accept = (state == S_IDLE) && instr_valid;
    assign ir_d   = accept ? instruction : ir;
    assign op_d   = ir_d[OP_W-1:0];
    assign wpn_d  = ir_d[OP_W + 2*REG_AW +: REG_AW];

    // Opcode classification of the instruction that will be in ir after this edge.
    always_comb begin
        legal_d  = 1'b0;
        writes_d = 1'b0;
        case (op_d)
            OP_NOP, OP_JZ, OP_JMP, OP_HALT:         legal_d = 1'b1;
            OP_ADD, OP_SUB, OP_AND, OP_LOADI, OP_ADDI: begin
                legal_d  = 1'b1;
                writes_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (instr_valid) next_state = S_DECODE;
            S_DECODE: begin
                if (!legal_d)              next_state = S_IDLE;
                else if (op_d == OP_HALT)  next_state = S_HALT;
                else                       next_state = S_EXEC;
            end
            S_EXEC:   next_state = S_WB;
            S_WB:     next_state = S_IDLE;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; mux selects hold unless a stage sets them.
    always_comb begin
        instr_ready_d = (next_state == S_IDLE);
        halted_d      = (next_state == S_HALT);
        illegal_d     = (next_state == S_DECODE) && !legal_d;
        alu_en_d      = 2'b00;
        write_en_d    = 1'b0;
        pc_load_d     = 1'b0;
        m1_d          = M1;
        m2_d          = M2;
        m3_d          = M3;
        m4_d          = M4;
        case (next_state)
            S_DECODE: begin
                m1_d = 2'b00;
                m2_d = 1'b0;
                m3_d = 2'b00;
                m4_d = 1'b0;
            end
            S_EXEC: begin
                m1_d = 2'b00;
                m2_d = (op_d == OP_ADDI);
                case (op_d)
                    OP_ADD, OP_ADDI: alu_en_d = 2'b01;
                    OP_SUB:          alu_en_d = 2'b10;
                    OP_AND:          alu_en_d = 2'b11;
                    default:         alu_en_d = 2'b00;
                endcase
            end
            S_WB: begin
                // z is only looked at on the EXEC->WB edge; M4 doubles as the taken flag.
                pc_load_d  = 1'b1;
                write_en_d = writes_d && !((R0_PROTECT != 0) && (wpn_d == '0));
                m3_d       = (op_d == OP_LOADI) ? 2'b01 : 2'b00;
                m4_d       = (op_d == OP_JMP) || ((op_d == OP_JZ) && z);
            end
            default: ;
        endcase
    end

    // State, instruction and output registers; rst_en is stretched one cycle past rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            ir          <= '0;
            rst_q       <= 1'b1;
            rst_en      <= 1'b1;
            instr_ready <= 1'b0;
            halted      <= 1'b0;
            illegal     <= 1'b0;
            alu_en      <= 2'b00;
            write_en    <= 1'b0;
            pc_load     <= 1'b0;
            M1          <= 2'b00;
            M2          <= 1'b0;
            M3          <= 2'b00;
            M4          <= 1'b0;
        end else begin
            state       <= next_state;
            ir          <= ir_d;
            rst_q       <= 1'b0;
            rst_en      <= rst_q;
            instr_ready <= instr_ready_d;
            halted      <= halted_d;
            illegal     <= illegal_d;
            alu_en      <= alu_en_d;
            write_en    <= write_en_d;
            pc_load     <= pc_load_d;
            M1          <= m1_d;
            M2          <= m2_d;
            M3          <= m3_d;
            M4          <= m4_d;
        end
    end

endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: directed vectors for control_fsm at default parameters.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_control_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [35:0] instruction;
    logic        instr_valid;
    logic        instr_ready;
    logic        z;
    logic [1:0]  alu_en, M1, M3;
    logic        M2, M4;
    logic [4:0]  rpa, rpb, wpn;
    logic [16:0] imm;
    logic        rst_en, write_en, pc_load, halted, illegal;

    int n_vec = 0;
    int n_bad = 0;

    control_fsm #(
        .INSTR_W(36), .OP_W(4), .REG_AW(5), .R0_PROTECT(1)
    ) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .z(z), .alu_en(alu_en), .M1(M1), .M2(M2),
        .M3(M3), .M4(M4), .rpa(rpa), .rpb(rpb), .wpn(wpn), .imm(imm),
        .rst_en(rst_en), .write_en(write_en), .pc_load(pc_load),
        .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [35:0] mk(input logic [3:0] op, input logic [4:0] a,
                                       input logic [4:0] b, input logic [4:0] w,
                                       input logic [16:0] im);
        return {im, w, b, a, op};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    // Present an instruction for one edge; returns at the DECODE-cycle negedge.
    task automatic issue(input logic [35:0] ins);
        instruction = ins;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instruction = '0; z = 1'b0;

        // 1: reset held for three edges, then released
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_rst_en", rst_en, 1);
            chk("rst_ready", instr_ready, 0);
            chk("rst_ctl", {alu_en, M1, M2, M3, M4, write_en, pc_load, halted, illegal}, 0);
        end
        rst = 1'b0;
        step();
        chk("rel_rst_en_tail", rst_en, 1);
        chk("rel_ready", instr_ready, 1);
        chk("rel_fields", {rpa, rpb, wpn, imm}, 0);
        step();
        chk("rel_rst_en_off", rst_en, 0);

        // 2: ADD r9 = r3 + r7, with SUB queued behind it
        issue(mk(4'h1, 5'd3, 5'd7, 5'd9, 17'h0));
        instruction = mk(4'h2, 5'd1, 5'd2, 5'd5, 17'h0);
        instr_valid = 1'b1;
        chk("add_dec_ready", instr_ready, 0);
        chk("add_dec_regs", {rpa, rpb, wpn}, {5'd3, 5'd7, 5'd9});
        chk("add_dec_alu", alu_en, 2'b00);
        step();
        chk("add_exec_alu", alu_en, 2'b01);
        chk("add_exec_m12", {M1, M2}, 3'b000);
        chk("add_exec_we", write_en, 0);
        step();
        chk("add_wb_ctl", {write_en, M3, pc_load, M4}, 5'b1_00_1_0);
        chk("add_wb_alu", alu_en, 2'b00);
        chk("add_wb_regs", {rpa, rpb, wpn}, {5'd3, 5'd7, 5'd9});
        step();
        chk("add_idle_ready", instr_ready, 1);
        chk("add_idle_strobes", {write_en, pc_load}, 2'b00);
        step();
        instr_valid = 1'b0;
        chk("sub_dec_regs", {rpa, rpb, wpn}, {5'd1, 5'd2, 5'd5});
        chk("sub_dec_ready", instr_ready, 0);
        step();
        chk("sub_exec_alu", alu_en, 2'b10);
        step(); step();

        // ADDI: immediate B operand, held through WB, cleared by next DECODE
        issue(mk(4'h5, 5'd2, 5'd0, 5'd6, 17'h00042));
        step();
        chk("addi_exec", {alu_en, M1, M2}, 5'b01_00_1);
        step();
        chk("addi_wb", {write_en, M2, M3, pc_load}, 5'b1_1_00_1);
        step();

        // 3: LOADI to r0 is blocked, to r4 is written
        issue(mk(4'h4, 5'd0, 5'd0, 5'd0, 17'h1ABCD));
        chk("ld0_dec_m2_clr", M2, 0);
        chk("ld0_dec_imm", imm, 17'h1ABCD);
        step();
        chk("ld0_exec_alu", alu_en, 2'b00);
        step();
        chk("ld0_wb", {M3, write_en, pc_load}, 4'b01_0_1);
        chk("ld0_wb_imm", imm, 17'h1ABCD);
        step();
        issue(mk(4'h4, 5'd0, 5'd0, 5'd4, 17'h1ABCD));
        step(); step();
        chk("ld4_wb", {M3, write_en, pc_load}, 4'b01_1_1);
        step();
        chk("ld4_idle_m3_held", M3, 2'b01);

        // 4: JZ taken, then JZ with z high only outside EXEC
        issue(mk(4'h8, 5'd0, 5'd0, 5'd0, 17'h00010));
        chk("jz1_dec_m3_clr", M3, 2'b00);
        step();
        z = 1'b1;
        step();
        z = 1'b0;
        chk("jz1_wb", {M4, pc_load, write_en}, 3'b1_1_0);
        step();
        issue(mk(4'h8, 5'd0, 5'd0, 5'd0, 17'h00010));
        z = 1'b1;
        chk("jz0_dec_m4_clr", M4, 0);
        step();
        z = 1'b0;
        step();
        z = 1'b1;
        chk("jz0_wb", {M4, pc_load}, 2'b0_1);
        step();
        z = 1'b0;
        issue(mk(4'h9, 5'd0, 5'd0, 5'd0, 17'h00020));
        step(); step();
        chk("jmp_wb", {M4, pc_load, write_en}, 3'b1_1_0);
        step();

        // 5: illegal opcode, then HALT
        issue(mk(4'h6, 5'd1, 5'd1, 5'd1, 17'h0));
        chk("ill_dec", {illegal, instr_ready, write_en, pc_load}, 4'b1000);
        step();
        chk("ill_idle", {illegal, instr_ready, write_en, pc_load}, 4'b0100);
        issue(mk(4'hF, 5'd0, 5'd0, 5'd0, 17'h0));
        chk("halt_dec", {halted, instr_ready}, 2'b00);
        for (int i = 0; i < 4; i++) begin
            instr_valid = i[0];
            instruction = mk(4'h1, 5'd1, 5'd1, 5'd1, 17'h0);
            step();
            chk("halt_hold", {halted, instr_ready, pc_load, write_en}, 4'b1000);
        end
        instr_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("halt_rst", {halted, rst_en, instr_ready}, 3'b010);
        step();
        chk("halt_rel", {rst_en, instr_ready}, 2'b11);
        step();
        chk("halt_rel2", rst_en, 0);

        // 6: reset during EXEC of ADD aborts it
        issue(mk(4'h1, 5'd3, 5'd7, 5'd9, 17'h0));
        step();
        chk("ab_exec_alu", alu_en, 2'b01);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("ab_rst", {rst_en, write_en, pc_load, alu_en, instr_ready}, 6'b1_0_0_00_0);
        chk("ab_rst_regs", {rpa, rpb, wpn}, 0);
        step();
        chk("ab_rel", {rst_en, write_en, pc_load, instr_ready}, 4'b1001);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ab_after", {rst_en, write_en, pc_load, instr_ready}, 4'b0001);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
